// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_din,
  input  logic                       uart_tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout,
  output logic [15:0]                tx_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         din_q, din_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               err_q, err_d;
  logic [15:0]        tx_count_q, tx_count_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic               rr_found;
  logic [IDW-1:0]     rr_winner;
  logic [7:0]         rr_data;
  logic               grant_go, done_evt, timeout_evt, gap_exit;

  // Requesters above the last grant take precedence; otherwise wrap to the lowest valid index.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_data   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!rr_found && req_valid[j] && (IDW'(j) > grant_id_q)) begin
        rr_found  = 1'b1;
        rr_winner = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!rr_found && req_valid[j]) begin
        rr_found  = 1'b1;
        rr_winner = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rr_winner == IDW'(j)) rr_data = req_data[8*j +: 8];
    end
  end

  assign grant_go    = (state_q == IDLE) && arb_en && rr_found;
  assign done_evt    = (state_q == SEND) && uart_tx_done;
  assign timeout_evt = (state_q == SEND) && !uart_tx_done && (wd_q == WD_LAST);
  // Waiting for done to fall tolerates a UART that holds done until the next enable.
  assign gap_exit    = (state_q == GAP) && (gap_q >= GAP_LAST) && !uart_tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_en_q     <= 1'b0;
      din_q       <= 8'h00;
      busy_q      <= 1'b0;
      grant_id_q  <= IDW'(NUM_REQ - 1);
      err_q       <= 1'b0;
      tx_count_q  <= 16'h0000;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_en_q     <= tx_en_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      err_q       <= err_d;
      tx_count_q  <= tx_count_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_go) state_d = SEND;
      SEND:    if (done_evt || timeout_evt) state_d = GAP;
      GAP:     if (gap_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    err_d       = 1'b0;
    tx_en_d     = tx_en_q;
    din_d       = din_q;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    tx_count_d  = tx_count_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (grant_go) begin
          req_ready_d = NUM_REQ'(1) << rr_winner;
          din_d       = rr_data;
          grant_id_d  = rr_winner;
          tx_en_d     = 1'b1;
          busy_d      = 1'b1;
          wd_d        = '0;
        end
      end
      SEND: begin
        wd_d = wd_q + WDW'(1);
        if (done_evt || timeout_evt) begin
          tx_en_d = 1'b0;
          gap_d   = '0;
        end
        if (done_evt)    tx_count_d = tx_count_q + 16'd1;
        if (timeout_evt) err_d      = 1'b1;
      end
      GAP: begin
        if (gap_exit)              busy_d = 1'b0;
        else if (gap_q < GAP_LAST) gap_d  = gap_q + GW'(1);
      end
      default: ;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign uart_tx_en  = tx_en_q;
  assign uart_din    = din_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_q;
  assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a stub UART
module tb_uart_tx_arbiter;
  localparam int GAP = 2;

  logic        clk, rst, arb_en, uart_tx_done;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        uart_tx_en, busy, err_timeout;
  logic [7:0]  uart_din;
  logic [1:0]  grant_id;
  logic [15:0] tx_count;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(50), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_tx_en(uart_tx_en), .uart_din(uart_din),
    .uart_tx_done(uart_tx_done), .busy(busy), .grant_id(grant_id),
    .err_timeout(err_timeout), .tx_count(tx_count)
  );

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  int          checks = 0, errors = 0, grant_cnt = 0;
  logic [3:0]  reload = '0;
  int          stub_mode = 1, stub_delay = 10, stub_hold = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Stub UART: done after stub_delay enabled cycles, optionally held stub_hold cycles after enable drops
  initial begin
    int en_cnt, hold_left;
    en_cnt = 0; hold_left = 0; uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0; hold_left = 0; uart_tx_done = 1'b0;
      end else if (uart_tx_en) begin
        en_cnt++;
        if (stub_mode != 0 && en_cnt == stub_delay) begin
          uart_tx_done = 1'b1;
          hold_left = stub_hold;
        end
      end else begin
        en_cnt = 0;
        if (hold_left > 0) hold_left--;
        else uart_tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accept pulse and models requester release
  initial begin
    logic [3:0] prev_ready;
    logic       prev_en, had_byte;
    int         low_run, id;
    exp_t       e;
    prev_ready = '0; prev_en = 1'b0; had_byte = 1'b0; low_run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_ready = '0; prev_en = 1'b0; had_byte = 1'b0; low_run = 0;
      end else begin
        if (req_ready != 4'b0) begin
          id = 0;
          for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
          chk("ready single cycle", {28'd0, req_ready & prev_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected grant", {28'd0, req_ready}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("grant ready/din/id/en",
                {18'd0, req_ready, uart_din, grant_id, uart_tx_en},
                {18'd0, 4'b0001 << e.id, e.data, e.id, 1'b1});
          end
          if (!reload[id]) req_valid[id] = 1'b0;
          grant_cnt++;
        end
        if (!uart_tx_en) low_run++;
        else begin
          if (!prev_en && had_byte) chk("gap low cycles >= GAP", {31'd0, low_run >= GAP}, 32'd1);
          low_run = 0;
          had_byte = 1'b1;
        end
        prev_en = uart_tx_en;
        prev_ready = req_ready;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      n++;
      @(negedge clk);
    end
    chk("wait idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic offer(input int id, input logic [7:0] d);
    exp_t e;
    req_data[8*id +: 8] = d;
    req_valid[id] = 1'b1;
    e.id = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int n, m;
    rst = 1'b1; arb_en = 1'b1; req_valid = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {7'd0, req_ready, uart_tx_en, uart_din, busy, grant_id, err_timeout, tx_count},
        {7'd0, 4'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 16'd0});
    rst = 1'b0;

    // Single requester 2
    @(negedge clk);
    offer(2, 8'hA5);
    @(posedge clk); #1;
    chk("t1 latency ready", {28'd0, req_ready}, 32'h4);
    chk("t1 latency tx_en", {31'd0, uart_tx_en}, 32'd1);
    wait_idle(100);
    chk("t1 tx_count", {16'd0, tx_count}, 32'd1);
    chk("t1 grant_id", {30'd0, grant_id}, 32'd2);

    // Fairness with all four held valid
    do_reset();
    grant_cnt = 0;
    reload = 4'hF;
    offer(0, 8'h11); offer(1, 8'h22); offer(2, 8'h33); offer(3, 8'h44);
    begin
      exp_t e;
      e.id = 2'd0; e.data = 8'h11; exp_q.push_back(e);
    end
    n = 0;
    while (grant_cnt < 5 && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("t2 five grants", {31'd0, grant_cnt >= 5}, 32'd1);
    reload = '0; req_valid = '0;
    wait_idle(200);
    chk("t2 tx_count", {16'd0, tx_count}, 32'd5);

    // Watchdog timeout
    do_reset();
    stub_mode = 0;
    @(negedge clk);
    offer(1, 8'h5C);
    @(posedge clk); #1;
    n = 0;
    while (uart_tx_en && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t3 tx_en high cycles", n, 32'd50);
    chk("t3 err pulse", {31'd0, err_timeout}, 32'd1);
    chk("t3 tx_count unchanged", {16'd0, tx_count}, 32'd0);
    @(posedge clk); #1;
    chk("t3 err one cycle", {31'd0, err_timeout}, 32'd0);
    stub_mode = 1;
    wait_idle(100);
    offer(3, 8'h3C);
    @(posedge clk); #1;
    chk("t3 next grant", {28'd0, req_ready}, 32'h8);
    wait_idle(100);
    chk("t3 tx_count after", {16'd0, tx_count}, 32'd1);

    // Done held high after completion
    do_reset();
    stub_delay = 5; stub_hold = 20;
    @(negedge clk);
    offer(0, 8'h77);
    @(posedge clk); #1;
    n = 0;
    while (uart_tx_en && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t4 first count", {16'd0, tx_count}, 32'd1);
    offer(2, 8'h99);
    m = 0;
    while (!uart_tx_en && m < 100) begin
      m++;
      @(posedge clk); #1;
    end
    chk("t4 held in gap", {31'd0, m >= 21}, 32'd1);
    chk("t4 no double count", {16'd0, tx_count}, 32'd1);
    wait_idle(200);
    chk("t4 final count", {16'd0, tx_count}, 32'd2);

    // arb_en gating
    do_reset();
    stub_delay = 10; stub_hold = 0;
    arb_en = 1'b0;
    @(negedge clk);
    req_data[15:8] = 8'hB1;
    req_valid[1] = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5 no grant while disabled", {30'd0, busy, uart_tx_en}, 32'd0);
    offer(1, 8'hB1);
    arb_en = 1'b1;
    @(posedge clk); #1;
    chk("t5 grant after enable", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    arb_en = 1'b0;
    wait_idle(100);
    chk("t5 completes with arb_en low", {16'd0, tx_count}, 32'd1);
    arb_en = 1'b1;

    // Reset mid-SEND
    do_reset();
    stub_mode = 0;
    @(negedge clk);
    offer(2, 8'hC2);
    @(posedge clk); #1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 async reset outputs", {7'd0, req_ready, uart_tx_en, uart_din, busy, grant_id, err_timeout, tx_count},
        {7'd0, 4'b0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 16'd0});
    @(negedge clk);
    rst = 1'b0;
    stub_mode = 1;
    offer(0, 8'h0A);
    offer(3, 8'h3A);
    @(posedge clk); #1;
    chk("t6 req0 first", {28'd0, req_ready}, 32'h1);
    wait_idle(100);
    wait_idle(100);
    chk("t6 tx_count", {16'd0, tx_count}, 32'd2);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
